sdram_arbiter: RTL and testbench
================================

# sdram_arbiter

Command scheduler for the 16-bit SDRAM controller, in the `clk_sdr` domain. It sits between three requesters and the controller's `sys_CMD`/`sys_ADDR` port:
- the video refill path, requesting when the video queue is almost empty;
- cache write-back;
- cache line fill.

It issues one command at a time and advances the video read pointer with frame wrap. It steers returned read beats either to the cache or to the video queue, packing video beats into 32-bit words.

## Interface
Parameters:
- VID_LINES, 19200: number of 32-byte video bursts per frame (640*480*2/32).
- MAX_VID_RUN, 4: maximum consecutive video grants while a cache request is pending.
- CADDR_W, 17: cache line address width (256-byte units).

Ports:
- clk  in  1  SDRAM-domain clock (`clk_sdr`).
- reset  in  1  synchronous, active-high.
- vid_en  in  1  video refill enabled.
- vid_low  in  1  video queue almost empty (already synchronized to clk).
- frame_sync  in  1  single-cycle pulse; restart video pointer at 0.
- wb_req  in  1  cache write-back request (level).
- wb_addr  in  CADDR_W  line address of write-back.
- fill_req  in  1  cache fill request (level).
- fill_addr  in  CADDR_W  line address of fill.
- sys_cmd  out  2  00 nop, 01 write 256 B, 10 read 32 B video, 11 read 256 B.
- sys_addr  out  23  word address to controller.
- sys_cmd_ack  in  2  controller acknowledge, echoes accepted command.
- sys_rd_data_valid  in  1  read beat valid.
- sys_wr_data_valid  in  1  write beat requested.
- sys_dout  in  16  read beat data.
- cache_wr  out  1  read beat belongs to the cache (valid & route_cache).
- cache_rd  out  1  write beat requested for the cache (wr_valid & route_cache).
- vq_we  out  1  push to video queue.
- vq_data  out  32  {second beat, first beat}.
- vidadr  out  19  current video burst index.
- wb_gnt, fill_gnt  out  1  single-cycle pulse when the respective command is acknowledged.

## Operation
States: IDLE, ISSUE, GAP.

IDLE:
- Select the winner and load sys_cmd/sys_addr in the same cycle, then go to ISSUE.
- Priority: video (vid_en & vid_low), then write-back, then fill.
- Exception: if vid_run == MAX_VID_RUN and a cache request is pending, cache wins.

Address formation:
- Video: sys_addr = {1'b1, vidadr, 3'b000}.
- Write-back: sys_addr = {wb_addr, 6'b0}.
- Fill: sys_addr = {fill_addr, 6'b0}.
- Only the low 23 bits are driven.

ISSUE:
- Hold sys_cmd and sys_addr stable until sys_cmd_ack == sys_cmd, then go to GAP.
- On acknowledge of video:
  - route_cache <= 0;
  - vidadr <= (vidadr == VID_LINES-1) ? 0 : vidadr+1;
  - vid_run <= vid_run+1, saturating at MAX_VID_RUN.
- On acknowledge of a cache command:
  - route_cache <= 1;
  - vid_run <= 0;
  - pulse wb_gnt or fill_gnt.
- An ack value not equal to sys_cmd is ignored.

GAP:
- sys_cmd = 00 for exactly one cycle, then IDLE.
- Requesters must drop or update their request in response to the gnt pulse.

Video beat packing:
- While route_cache == 0, each sys_rd_data_valid toggles a phase bit.
- Phase 0: latch the beat into a low-half register.
- Phase 1: vq_we = 1 for one cycle, with vq_data = {sys_dout, low}.
- The phase bit clears on every video acknowledge, so a burst always starts at phase 0.

frame_sync:
- Sets vidadr to 0. If it coincides with a video acknowledge, frame_sync wins (vidadr = 0).
- Does not abort a command in flight.

## Timing
- Reset values: sys_cmd=00, sys_addr=0, vidadr=0, vid_run=0, route_cache=1, phase=0, vq_we=0, vq_data=0, wb_gnt=fill_gnt=0, state IDLE.
- Reset mid-command drops sys_cmd to 00 on the next edge. The controller's own recovery is out of scope.
- Request to sys_cmd valid: 1 cycle (registered) from IDLE.
- Minimum command-to-command spacing: acknowledge cycle + 1 GAP cycle + 1 IDLE cycle.
- cache_wr and cache_rd are combinational from the valid inputs and the registered route_cache; zero latency.
- vq_we is asserted the cycle after the second beat is sampled (registered output).
- A request arriving in ISSUE or GAP waits; requests are levels, not latched.
- vid_low deasserting during ISSUE does not withdraw a video command.

## Test plan
- Fill only: fill_req=1, fill_addr=0x00123 → sys_cmd=11, sys_addr=0x0048C0; ack=11 → fill_gnt pulse, route_cache=1, 16 valid beats yield 16 cache_wr, vq_we=0.
- Video burst: vid_en=vid_low=1, vidadr=5 → sys_cmd=10, sys_addr=0x400028. Ack then beats 0x1111, 0x2222 → vq_data=0x22221111. 16 beats give 8 pushes; vidadr=6.
- Wrap: vidadr=19199, ack video → vidadr=0. frame_sync coincident with ack at vidadr=7 → vidadr=0.
- Starvation: vid_low held high and wb_req=1 → exactly 4 video commands, then one write-back (sys_cmd=01), then video resumes.
- Priority: wb_req and fill_req both high → write-back first; fill issued after the GAP cycle.
- Reset mid-ISSUE: reset=1 while sys_cmd=11 → next edge sys_cmd=00, vidadr=0, route_cache=1; a wrong ack (10 while cmd=11) before reset leaves the state in ISSUE.

Source files
------------

// File: rtl/sdram_arbiter.sv
// Command scheduler for the SDRAM controller: arbitrates video refill, cache write-back and
// cache fill, advances the video burst pointer and packs video read beats into 32-bit words.
module sdram_arbiter #(
  parameter int VID_LINES   = 19200,
  parameter int MAX_VID_RUN = 4,
  parameter int CADDR_W     = 17
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vid_en,
  input  logic               vid_low,
  input  logic               frame_sync,
  input  logic               wb_req,
  input  logic [CADDR_W-1:0] wb_addr,
  input  logic               fill_req,
  input  logic [CADDR_W-1:0] fill_addr,
  output logic [1:0]         sys_cmd,
  output logic [22:0]        sys_addr,
  input  logic [1:0]         sys_cmd_ack,
  input  logic               sys_rd_data_valid,
  input  logic               sys_wr_data_valid,
  input  logic [15:0]        sys_dout,
  output logic               cache_wr,
  output logic               cache_rd,
  output logic               vq_we,
  output logic [31:0]        vq_data,
  output logic [18:0]        vidadr,
  output logic               wb_gnt,
  output logic               fill_gnt
);

  localparam int               RUN_W    = $clog2(MAX_VID_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_VID_RUN);
  localparam logic [18:0]      VID_LAST = 19'(VID_LINES - 1);

  localparam logic [1:0] CMD_NOP = 2'b00;
  localparam logic [1:0] CMD_WR  = 2'b01;
  localparam logic [1:0] CMD_VID = 2'b10;
  localparam logic [1:0] CMD_RD  = 2'b11;

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  state_t           state_q, state_d;
  logic [1:0]       sys_cmd_q, sys_cmd_d;
  logic [22:0]      sys_addr_q, sys_addr_d;
  logic [18:0]      vidadr_q, vidadr_d;
  logic [RUN_W-1:0] vid_run_q, vid_run_d;
  logic             route_cache_q, route_cache_d;
  logic             phase_q, phase_d;
  logic [15:0]      low_q, low_d;
  logic             vq_we_q, vq_we_d;
  logic [31:0]      vq_data_q, vq_data_d;
  logic             wb_gnt_q, wb_gnt_d;
  logic             fill_gnt_q, fill_gnt_d;

  logic vid_want;
  logic cache_pend;
  logic starve;

  assign vid_want   = vid_en & vid_low;
  assign cache_pend = wb_req | fill_req;
  // After MAX_VID_RUN back-to-back video grants a waiting cache request gets the next slot.
  assign starve     = (vid_run_q == RUN_MAX) & cache_pend;

  always_comb begin
    state_d       = state_q;
    sys_cmd_d     = sys_cmd_q;
    sys_addr_d    = sys_addr_q;
    vidadr_d      = vidadr_q;
    vid_run_d     = vid_run_q;
    route_cache_d = route_cache_q;
    phase_d       = phase_q;
    low_d         = low_q;
    vq_we_d       = 1'b0;
    vq_data_d     = vq_data_q;
    wb_gnt_d      = 1'b0;
    fill_gnt_d    = 1'b0;

    if (!route_cache_q && sys_rd_data_valid) begin
      if (!phase_q) begin
        low_d   = sys_dout;
        phase_d = 1'b1;
      end else begin
        vq_we_d   = 1'b1;
        vq_data_d = {sys_dout, low_q};
        phase_d   = 1'b0;
      end
    end

    case (state_q)
      IDLE: begin
        if (vid_want && !starve) begin
          sys_cmd_d  = CMD_VID;
          sys_addr_d = {1'b1, vidadr_q, 3'b000};
          state_d    = ISSUE;
        end else if (wb_req) begin
          sys_cmd_d  = CMD_WR;
          sys_addr_d = 23'({wb_addr, 6'b000000});
          state_d    = ISSUE;
        end else if (fill_req) begin
          sys_cmd_d  = CMD_RD;
          sys_addr_d = 23'({fill_addr, 6'b000000});
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        // A mismatched acknowledge is ignored; the command stays on the bus.
        if (sys_cmd_ack == sys_cmd_q) begin
          state_d   = GAP;
          sys_cmd_d = CMD_NOP;
          if (sys_cmd_q == CMD_VID) begin
            route_cache_d = 1'b0;
            phase_d       = 1'b0;
            vidadr_d      = (vidadr_q == VID_LAST) ? 19'd0 : vidadr_q + 19'd1;
            if (vid_run_q != RUN_MAX) begin
              vid_run_d = vid_run_q + RUN_W'(1);
            end
          end else begin
            route_cache_d = 1'b1;
            vid_run_d     = '0;
            wb_gnt_d      = (sys_cmd_q == CMD_WR);
            fill_gnt_d    = (sys_cmd_q == CMD_RD);
          end
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        sys_cmd_d = CMD_NOP;
      end
    endcase

    if (frame_sync) begin
      vidadr_d = 19'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      sys_cmd_q     <= CMD_NOP;
      sys_addr_q    <= '0;
      vidadr_q      <= '0;
      vid_run_q     <= '0;
      route_cache_q <= 1'b1;
      phase_q       <= 1'b0;
      low_q         <= '0;
      vq_we_q       <= 1'b0;
      vq_data_q     <= '0;
      wb_gnt_q      <= 1'b0;
      fill_gnt_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      sys_cmd_q     <= sys_cmd_d;
      sys_addr_q    <= sys_addr_d;
      vidadr_q      <= vidadr_d;
      vid_run_q     <= vid_run_d;
      route_cache_q <= route_cache_d;
      phase_q       <= phase_d;
      low_q         <= low_d;
      vq_we_q       <= vq_we_d;
      vq_data_q     <= vq_data_d;
      wb_gnt_q      <= wb_gnt_d;
      fill_gnt_q    <= fill_gnt_d;
    end
  end

  assign sys_cmd  = sys_cmd_q;
  assign sys_addr = sys_addr_q;
  assign vidadr   = vidadr_q;
  assign vq_we    = vq_we_q;
  assign vq_data  = vq_data_q;
  assign wb_gnt   = wb_gnt_q;
  assign fill_gnt = fill_gnt_q;
  assign cache_wr = sys_rd_data_valid & route_cache_q;
  assign cache_rd = sys_wr_data_valid & route_cache_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed scenarios followed by randomized rounds checked
// against a rule-level model of arbitration, pointer wrap and beat packing.
module tb_sdram_arbiter;

  // Shortened frame so the pointer wrap is reached in a few dozen commands.
  localparam int VL      = 40;
  localparam int MAX_RUN = 4;
  localparam int CW      = 17;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          vid_en = 1'b0;
  logic          vid_low = 1'b0;
  logic          frame_sync = 1'b0;
  logic          wb_req = 1'b0;
  logic [CW-1:0] wb_addr = '0;
  logic          fill_req = 1'b0;
  logic [CW-1:0] fill_addr = '0;
  logic [1:0]    sys_cmd;
  logic [22:0]   sys_addr;
  logic [1:0]    sys_cmd_ack = 2'b00;
  logic          sys_rd_data_valid = 1'b0;
  logic          sys_wr_data_valid = 1'b0;
  logic [15:0]   sys_dout = '0;
  logic          cache_wr;
  logic          cache_rd;
  logic          vq_we;
  logic [31:0]   vq_data;
  logic [18:0]   vidadr;
  logic          wb_gnt;
  logic          fill_gnt;

  always #5 clk = ~clk;

  sdram_arbiter #(
    .VID_LINES  (VL),
    .MAX_VID_RUN(MAX_RUN),
    .CADDR_W    (CW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .vid_en           (vid_en),
    .vid_low          (vid_low),
    .frame_sync       (frame_sync),
    .wb_req           (wb_req),
    .wb_addr          (wb_addr),
    .fill_req         (fill_req),
    .fill_addr        (fill_addr),
    .sys_cmd          (sys_cmd),
    .sys_addr         (sys_addr),
    .sys_cmd_ack      (sys_cmd_ack),
    .sys_rd_data_valid(sys_rd_data_valid),
    .sys_wr_data_valid(sys_wr_data_valid),
    .sys_dout         (sys_dout),
    .cache_wr         (cache_wr),
    .cache_rd         (cache_rd),
    .vq_we            (vq_we),
    .vq_data          (vq_data),
    .vidadr           (vidadr),
    .wb_gnt           (wb_gnt),
    .fill_gnt         (fill_gnt)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: video pointer, consecutive video grants, beat routing, pending low half.
  int          m_vid = 0;
  int          m_run = 0;
  bit          m_route_cache = 1'b1;
  logic [15:0] m_low[$];

  int          push_count = 0;
  int          cache_wr_count = 0;
  logic [1:0]  got_cmd;
  logic [22:0] got_addr;
  int          cw0;
  int          p0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit en, input bit low, input bit wb, input logic [CW-1:0] wa,
                               input bit fr, input logic [CW-1:0] fa);
    vid_en    = en;
    vid_low   = low;
    wb_req    = wb;
    wb_addr   = wa;
    fill_req  = fr;
    fill_addr = fa;
  endtask

  task automatic modelReset();
    m_vid         = 0;
    m_run         = 0;
    m_route_cache = 1'b1;
    m_low.delete();
  endtask

  function automatic logic [1:0] expectedWinner();
    bit vw;
    bit cp;
    vw = vid_en && vid_low;
    cp = wb_req || fill_req;
    if (vw && !(m_run == MAX_RUN && cp)) return 2'b10;
    if (wb_req) return 2'b01;
    if (fill_req) return 2'b11;
    return 2'b00;
  endfunction

  // One arbitration round from IDLE: issue, optional wrong acks, correct ack, GAP, IDLE.
  task automatic doCommand(input int wrong_cycles, input bit fs_at_ack, input bit drop_low, input bit hold,
                           output logic [1:0] gc, output logic [22:0] ga);
    logic [1:0]  exp_cmd;
    logic [22:0] exp_addr;
    exp_cmd = expectedWinner();
    case (exp_cmd)
      2'b10:   exp_addr = 23'((1 << 22) + m_vid * 8);
      2'b01:   exp_addr = 23'(int'(wb_addr) * 64);
      2'b11:   exp_addr = 23'(int'(fill_addr) * 64);
      default: exp_addr = '0;
    endcase
    tick();
    gc = sys_cmd;
    ga = sys_addr;
    checkOutput("cmd_issue", sys_cmd, exp_cmd);
    if (exp_cmd == 2'b00) return;
    checkOutput("addr_issue", sys_addr, exp_addr);
    if (drop_low) vid_low = 1'b0;
    for (int i = 0; i < wrong_cycles; i++) begin
      sys_cmd_ack = 2'(exp_cmd + $urandom_range(1, 3));
      tick();
      checkOutput("cmd_hold", sys_cmd, exp_cmd);
      checkOutput("addr_hold", sys_addr, exp_addr);
    end
    sys_cmd_ack = exp_cmd;
    frame_sync  = fs_at_ack;
    tick();
    if (exp_cmd == 2'b10) begin
      m_route_cache = 1'b0;
      m_low.delete();
      m_vid = (m_vid + 1) % VL;
      if (m_run < MAX_RUN) m_run++;
    end else begin
      m_route_cache = 1'b1;
      m_run = 0;
    end
    if (fs_at_ack) m_vid = 0;
    checkOutput("cmd_gap", sys_cmd, 2'b00);
    checkOutput("wb_gnt", wb_gnt, exp_cmd == 2'b01);
    checkOutput("fill_gnt", fill_gnt, exp_cmd == 2'b11);
    checkOutput("vidadr", vidadr, m_vid);
    sys_cmd_ack = 2'b00;
    frame_sync  = 1'b0;
    if (!hold) begin
      applyStimulus(1'b0, 1'b0, 1'b0, wb_addr, 1'b0, fill_addr);
    end else begin
      if (exp_cmd == 2'b01) wb_req = 1'b0;
      if (exp_cmd == 2'b11) fill_req = 1'b0;
    end
    tick();
    checkOutput("cmd_idle", sys_cmd, 2'b00);
    checkOutput("gnt_pulse_wb", wb_gnt, 1'b0);
    checkOutput("gnt_pulse_fill", fill_gnt, 1'b0);
  endtask

  task automatic doBeat(input logic [15:0] d);
    bit          wrv;
    bit          exp_push;
    logic [31:0] exp_data;
    logic        seen_cw;
    wrv = 1'($urandom_range(0, 1));
    sys_rd_data_valid = 1'b1;
    sys_dout          = d;
    sys_wr_data_valid = wrv;
    #1;
    seen_cw = cache_wr;
    checkOutput("cache_wr", cache_wr, m_route_cache);
    checkOutput("cache_rd", cache_rd, wrv & m_route_cache);
    exp_push = 1'b0;
    exp_data = '0;
    if (!m_route_cache) begin
      if (m_low.size() == 0) begin
        m_low.push_back(d);
      end else begin
        exp_push = 1'b1;
        exp_data = {d, m_low.pop_front()};
      end
    end
    tick();
    sys_rd_data_valid = 1'b0;
    sys_wr_data_valid = 1'b0;
    checkOutput("vq_we", vq_we, exp_push);
    if (exp_push) checkOutput("vq_data", vq_data, exp_data);
    if (vq_we === 1'b1) push_count++;
    if (seen_cw === 1'b1) cache_wr_count++;
  endtask

  task automatic doBeats(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        tick();
        checkOutput("vq_idle", vq_we, 1'b0);
      end
      doBeat(16'($urandom));
    end
  endtask

  initial begin
    // Reset values
    reset = 1'b1;
    tick();
    tick();
    checkOutput("rst_cmd", sys_cmd, 2'b00);
    checkOutput("rst_addr", sys_addr, 23'h0);
    checkOutput("rst_vidadr", vidadr, 19'h0);
    checkOutput("rst_vq_we", vq_we, 1'b0);
    checkOutput("rst_vq_data", vq_data, 32'h0);
    checkOutput("rst_wb_gnt", wb_gnt, 1'b0);
    checkOutput("rst_fill_gnt", fill_gnt, 1'b0);
    sys_rd_data_valid = 1'b1;
    #1;
    checkOutput("rst_route", cache_wr, 1'b1);
    sys_rd_data_valid = 1'b0;
    reset = 1'b0;
    modelReset();
    tick();

    // Fill only
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 17'h00123);
    doCommand(1, 1'b0, 1'b0, 1'b0, got_cmd, got_addr);
    checkOutput("fill_cmd", got_cmd, 2'b11);
    checkOutput("fill_addr", got_addr, 23'h0048C0);
    cw0 = cache_wr_count;
    p0  = push_count;
    for (int i = 0; i < 16; i++) doBeat(16'($urandom));
    checkOutput("fill_cache_wr", cache_wr_count - cw0, 16);
    checkOutput("fill_no_push", push_count - p0, 0);

    // Video burst at pointer 5
    applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
    repeat (5) doCommand(0, 1'b0, 1'b0, 1'b1, got_cmd, got_addr);
    doCommand(0, 1'b0, 1'b0, 1'b0, got_cmd, got_addr);
    checkOutput("vid_cmd", got_cmd, 2'b10);
    checkOutput("vid_addr", got_addr, 23'h400028);
    checkOutput("vid_next", vidadr, 19'd6);
    p0 = push_count;
    doBeat(16'h1111);
    doBeat(16'h2222);
    checkOutput("vid_pack", vq_data, 32'h22221111);
    for (int i = 0; i < 14; i++) doBeat(16'($urandom));
    checkOutput("vid_pushes", push_count - p0, 8);

    // Pointer wrap at the last burst of the frame
    applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < VL && m_vid != VL - 1; i++) doCommand(0, 1'b0, 1'b0, 1'b1, got_cmd, got_addr);
    checkOutput("wrap_pre", vidadr, VL - 1);
    doCommand(0, 1'b0, 1'b0, 1'b0, got_cmd, got_addr);
    checkOutput("wrap", vidadr, 19'd0);

    // frame_sync coincident with a video acknowledge
    applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < VL && m_vid != 7; i++) doCommand(0, 1'b0, 1'b0, 1'b1, got_cmd, got_addr);
    checkOutput("fs_pre", vidadr, 19'd7);
    doCommand(0, 1'b1, 1'b0, 1'b0, got_cmd, got_addr);
    checkOutput("fs_ack", vidadr, 19'd0);

    // frame_sync while idle
    applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
    doCommand(0, 1'b0, 1'b0, 1'b1, got_cmd, got_addr);
    doCommand(0, 1'b0, 1'b0, 1'b1, got_cmd, got_addr);
    doCommand(0, 1'b0, 1'b0, 1'b0, got_cmd, got_addr);
    checkOutput("fs_idle_pre", vidadr, 19'd3);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    m_vid = 0;
    checkOutput("fs_idle", vidadr, 19'd0);

    // Write-back beats fill; fill must wait for the GAP and IDLE cycles
    applyStimulus(1'b0, 1'b0, 1'b1, 17'h1ABCD, 1'b1, 17'h00042);
    doCommand(0, 1'b0, 1'b0, 1'b1, got_cmd, got_addr);
    checkOutput("prio_first", got_cmd, 2'b01);
    doCommand(0, 1'b0, 1'b0, 1'b0, got_cmd, got_addr);
    checkOutput("prio_second", got_cmd, 2'b11);

    // Starvation: four video grants, then the waiting write-back, then video again
    applyStimulus(1'b1, 1'b1, 1'b1, 17'h00777, 1'b0, '0);
    for (int i = 0; i < 6; i++) begin
      doCommand(0, 1'b0, 1'b0, i < 5, got_cmd, got_addr);
      checkOutput("starve_seq", got_cmd, (i < 4) ? 2'b10 : (i == 4) ? 2'b01 : 2'b10);
    end

    // Reset in the middle of an ISSUE, after a mismatched acknowledge
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 17'h00055);
    tick();
    checkOutput("rm_cmd", sys_cmd, 2'b11);
    sys_cmd_ack = 2'b10;
    tick();
    checkOutput("rm_wrong_ack", sys_cmd, 2'b11);
    sys_cmd_ack = 2'b00;
    fill_req = 1'b0;
    reset = 1'b1;
    tick();
    checkOutput("rm_cmd_drop", sys_cmd, 2'b00);
    checkOutput("rm_vidadr", vidadr, 19'd0);
    sys_rd_data_valid = 1'b1;
    #1;
    checkOutput("rm_route", cache_wr, 1'b1);
    sys_rd_data_valid = 1'b0;
    reset = 1'b0;
    modelReset();
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 17'h00abc, 1'b0, '0);
    doCommand(0, 1'b0, 1'b0, 1'b0, got_cmd, got_addr);

    // Randomized rounds
    for (int r = 0; r < 60; r++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                    CW'($urandom), $urandom_range(0, 2) == 0, CW'($urandom));
      doCommand($urandom_range(0, 2), $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, 1'b0,
                got_cmd, got_addr);
      applyStimulus(1'b0, 1'b0, 1'b0, wb_addr, 1'b0, fill_addr);
      doBeats($urandom_range(0, 12));
      if ($urandom_range(0, 9) == 0) begin
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        m_vid = 0;
        checkOutput("fs_rand", vidadr, 19'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
